// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - N-channel countdown timer with shared tick/blink prescalers
module multi_channel_timer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1,
    parameter int BLINK_HZ = 2,
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         start,
    input  logic [CHANNELS-1:0]         cancel,
    input  logic [CHANNELS-1:0]         mode,
    input  logic [CHANNELS*COUNT_W-1:0] load_value,
    output logic                        tick_enable,
    output logic                        blink_enable,
    output logic [CHANNELS-1:0]         busy,
    output logic [CHANNELS-1:0]         expired,
    output logic [CHANNELS-1:0]         expired_pulse,
    output logic [CHANNELS*COUNT_W-1:0] remaining
);

    localparam int TICK_DIV  = CLK_FREQ / TICK_HZ;
    localparam int BLINK_DIV = CLK_FREQ / BLINK_HZ;
    localparam int TICK_W    = $clog2(TICK_DIV);
    localparam int BLINK_W   = $clog2(BLINK_DIV);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt     <= '0;
            blink_cnt    <= '0;
            tick_enable  <= 1'b0;
            blink_enable <= 1'b0;
        end else begin
            tick_enable  <= (tick_cnt == TICK_LAST);
            blink_enable <= (blink_cnt == BLINK_LAST);
            tick_cnt     <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
            blink_cnt    <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [TICK_W-1:0]  sub;
        logic [COUNT_W-1:0] val;
        logic [COUNT_W-1:0] rem;
        logic [COUNT_W-1:0] load_v;
        logic               auto_reload;
        logic               ch_busy;
        logic               ch_expired;
        logic               ch_pulse;
        logic               zero_pend;

        assign load_v = load_value[i*COUNT_W +: COUNT_W];

        // A zero-length start flags expiry at once but strobes one cycle later.
        always_ff @(posedge clock) begin
            if (reset) begin
                sub         <= '0;
                val         <= '0;
                rem         <= '0;
                auto_reload <= 1'b0;
                ch_busy     <= 1'b0;
                ch_expired  <= 1'b0;
                ch_pulse    <= 1'b0;
                zero_pend   <= 1'b0;
            end else begin
                ch_pulse <= 1'b0;
                if (start[i]) begin
                    val         <= load_v;
                    auto_reload <= mode[i];
                    sub         <= '0;
                    if (load_v != '0) begin
                        ch_busy    <= 1'b1;
                        rem        <= load_v;
                        ch_expired <= 1'b0;
                        zero_pend  <= 1'b0;
                    end else begin
                        ch_busy    <= 1'b0;
                        rem        <= '0;
                        ch_expired <= 1'b1;
                        zero_pend  <= 1'b1;
                    end
                end else if (cancel[i]) begin
                    ch_busy    <= 1'b0;
                    rem        <= '0;
                    ch_expired <= 1'b0;
                    sub        <= '0;
                    zero_pend  <= 1'b0;
                end else begin
                    zero_pend <= 1'b0;
                    if (zero_pend) ch_pulse <= 1'b1;
                    if (ch_busy) begin
                        if (sub == TICK_LAST) begin
                            sub <= '0;
                            if (rem == COUNT_W'(1)) begin
                                ch_expired <= 1'b1;
                                ch_pulse   <= 1'b1;
                                if (auto_reload) begin
                                    rem <= val;
                                end else begin
                                    rem     <= '0;
                                    ch_busy <= 1'b0;
                                end
                            end else if (rem != '0) begin
                                rem <= rem - COUNT_W'(1);
                            end
                        end else begin
                            sub <= sub + TICK_W'(1);
                        end
                    end
                end
            end
        end

        assign busy[i]                            = ch_busy;
        assign expired[i]                         = ch_expired;
        assign expired_pulse[i]                   = ch_pulse;
        assign remaining[i*COUNT_W +: COUNT_W]    = rem;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// tb/tb_multi_channel_timer.sv - randomized and directed check of multi_channel_timer
module tb_multi_channel_timer;
    localparam int CH = 4;
    localparam int CW = 4;
    localparam int TD = 8;
    localparam int BD = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] start = '0;
    logic [CH-1:0] cancel = '0;
    logic [CH-1:0] mode = '0;
    logic [CH*CW-1:0] load_value = '0;
    logic          tick_enable;
    logic          blink_enable;
    logic [CH-1:0] busy;
    logic [CH-1:0] expired;
    logic [CH-1:0] expired_pulse;
    logic [CH*CW-1:0] remaining;

    multi_channel_timer #(
        .CLK_FREQ(8), .TICK_HZ(1), .BLINK_HZ(2), .CHANNELS(CH), .COUNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cancel(cancel), .mode(mode),
        .load_value(load_value), .tick_enable(tick_enable), .blink_enable(blink_enable),
        .busy(busy), .expired(expired), .expired_pulse(expired_pulse), .remaining(remaining)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int n = 0;

    // Channel model: expectations follow from elapsed time since the start edge.
    bit m_act [CH];
    bit m_mode[CH];
    bit m_exp [CH];
    bit m_pls [CH];
    int m_v   [CH];
    int m_st  [CH];
    int m_zat [CH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d n=%0d", name, act, exp, n);
        end
    endtask

    function automatic int model_rem(input int i);
        int p;
        if (!m_act[i]) return 0;
        p = m_v[i] * TD;
        return m_v[i] - (((n - m_st[i]) % p) / TD);
    endfunction

    task automatic model_edge();
        int p;
        if (reset) begin
            n = 0;
            for (int i = 0; i < CH; i++) begin
                m_act[i] = 0; m_exp[i] = 0; m_pls[i] = 0; m_zat[i] = -1;
            end
        end else begin
            n++;
            for (int i = 0; i < CH; i++) begin
                m_pls[i] = 0;
                if (start[i]) begin
                    m_v[i]    = int'(load_value[i*CW +: CW]);
                    m_mode[i] = mode[i];
                    m_st[i]   = n;
                    m_act[i]  = (m_v[i] > 0);
                    m_exp[i]  = (m_v[i] == 0);
                    m_zat[i]  = (m_v[i] == 0) ? n + 1 : -1;
                end else if (cancel[i]) begin
                    m_act[i] = 0; m_exp[i] = 0; m_zat[i] = -1;
                end else begin
                    if (m_zat[i] == n) begin
                        m_pls[i] = 1; m_zat[i] = -1;
                    end
                    if (m_act[i]) begin
                        p = m_v[i] * TD;
                        if ((n - m_st[i]) % p == 0) begin
                            m_pls[i] = 1;
                            m_exp[i] = 1;
                            if (!m_mode[i]) m_act[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("tick_enable", int'(tick_enable), int'(n > 0 && n % TD == 0));
        chk("blink_enable", int'(blink_enable), int'(n > 0 && n % BD == 0));
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_act[i]));
            chk($sformatf("expired[%0d]", i), int'(expired[i]), int'(m_exp[i]));
            chk($sformatf("expired_pulse[%0d]", i), int'(expired_pulse[i]), int'(m_pls[i]));
            chk($sformatf("remaining[%0d]", i), int'(remaining[i*CW +: CW]), model_rem(i));
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
        start  = '0;
        cancel = '0;
    endtask

    task automatic wait_to(input int target);
        int guard = 0;
        while (n < target && guard < 1000) begin
            step();
            guard++;
        end
        chk("wait_to_reached", n, target);
    endtask

    task automatic arm(input int i, input int v, input bit md);
        start[i] = 1'b1;
        mode[i]  = md;
        load_value[i*CW +: CW] = CW'(v);
    endtask

    int c;

    initial begin
        reset = 1'b1;
        step();
        step();
        chk("lit_reset_busy", int'(busy), 0);
        chk("lit_reset_remaining", int'(remaining), 0);
        reset = 1'b0;

        wait_to(4);  chk("lit_blink_4", int'(blink_enable), 1);
        wait_to(7);  chk("lit_tick_7", int'(tick_enable), 0);
        wait_to(8);  chk("lit_tick_8", int'(tick_enable), 1);
        wait_to(9);  chk("lit_tick_9", int'(tick_enable), 0);
        wait_to(40);

        arm(0, 3, 1'b0); step(); c = n;
        chk("lit_os_rem_start", int'(remaining[3:0]), 3);
        wait_to(c + 8);  chk("lit_os_rem_8", int'(remaining[3:0]), 2);
        wait_to(c + 23); chk("lit_os_pulse_23", int'(expired_pulse[0]), 0);
        wait_to(c + 24); chk("lit_os_pulse_24", int'(expired_pulse[0]), 1);
        chk("lit_os_busy_24", int'(busy[0]), 0);
        wait_to(c + 25); chk("lit_os_exp_25", int'(expired[0]), 1);

        arm(1, 2, 1'b1); arm(2, 0, 1'b0); step(); c = n;
        chk("lit_zero_exp", int'(expired[2]), 1);
        chk("lit_zero_pulse_c", int'(expired_pulse[2]), 0);
        step(); chk("lit_zero_pulse_c1", int'(expired_pulse[2]), 1);
        wait_to(c + 16); chk("lit_ar_pulse_16", int'(expired_pulse[1]), 1);
        chk("lit_ar_rem_16", int'(remaining[7:4]), 2);
        wait_to(c + 48); chk("lit_ar_pulse_48", int'(expired_pulse[1]), 1);
        chk("lit_ar_busy_48", int'(busy[1]), 1);

        arm(0, 3, 1'b0); step(); c = n;
        wait_to(c + 19); cancel[0] = 1'b1; step();
        chk("lit_cancel_busy", int'(busy[0]), 0);
        chk("lit_cancel_exp", int'(expired[0]), 0);
        wait_to(c + 30);
        arm(3, 5, 1'b0); cancel[3] = 1'b1; step();
        chk("lit_prio_rem", int'(remaining[15:12]), 5);

        arm(0, 2, 1'b0); step(); c = n;
        wait_to(c + 11); arm(0, 4, 1'b0); step();
        wait_to(c + 16); chk("lit_retrig_16", int'(expired_pulse[0]), 0);
        wait_to(c + 44); chk("lit_retrig_44", int'(expired_pulse[0]), 1);

        for (int i = 0; i < CH; i++) arm(i, 15, 1'(i & 1));
        step(); c = n;
        wait_to(c + 9); reset = 1'b1; step();
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_exp", int'(expired), 0);
        reset = 1'b0;
        wait_to(8); chk("lit_rst_tick_8", int'(tick_enable), 1);

        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    case ($urandom_range(0, 3))
                        0: arm(i, 0, 1'($urandom_range(0, 1)));
                        1: arm(i, 15, 1'($urandom_range(0, 1)));
                        default: arm(i, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
                    endcase
                end
                if ($urandom_range(0, 39) == 0) cancel[i] = 1'b1;
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
